// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-mapped responder on the processor's external bus.
// Decodes ADDR[15:12] into on-chip RAM, an LED register, a synchronized switch
// port and a down-counting timer. Writes commit on the edge where W is high;
// read data is registered, so DIN is valid one edge after ADDR is presented.
//
// Address map (ADDR[15:12]):
//   0x0  RAM word ADDR[RAM_AW-1:0] (upper offset bits ignored, RAM aliases)
//   0x1  LEDR (any offset)
//   0x3  SW   (read-only, any offset)
//   0x4  timer: ADDR[1:0] = 0 CTRL {AR,EN}, 1 COUNT, 2 RELOAD, 3 STATUS {TF}
//   else unmapped: reads 0, writes ignored
//
// Bus protocol: no valid/ready handshake. Every edge is a bus cycle; W=1 at an
// edge is a write that is always accepted, and DIN is reloaded every edge
// with the value addressed by ADDR before any write at that edge lands.
module mem_bus_responder #(
    parameter int RAM_AW = 8,
    parameter int LED_W  = 10,
    parameter int SW_W   = 10
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       DOUT,
    input  logic              W,
    output logic [15:0]       DIN,
    input  logic [SW_W-1:0]   SW,
    output logic [LED_W-1:0]  LEDR
);

    localparam int RAM_DEPTH = 2 ** RAM_AW;

    // Storage and registers
    logic [15:0]      r_ram [RAM_DEPTH];
    logic [LED_W-1:0] r_led;
    logic [SW_W-1:0]  r_sw_meta;
    logic [SW_W-1:0]  r_sw_sync;
    logic             r_en;
    logic             r_ar;
    logic             r_tf;
    logic [15:0]      r_count;
    logic [15:0]      r_reload;
    logic [15:0]      r_din;

    // Decode
    logic w_sel_ram;
    logic w_sel_led;
    logic w_sel_sw;
    logic w_sel_tmr;
    logic w_wr_ram;
    logic w_wr_led;
    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_reload;
    logic w_tf_clear;

    // Timer next-state
    logic        w_en_next;
    logic        w_ar_next;
    logic        w_tf_next;
    logic        w_tf_set;
    logic [15:0] w_count_next;

    logic [15:0] w_rd_data;
    logic        w_unused;

    assign w_sel_ram = (ADDR[15:12] == 4'h0);
    assign w_sel_led = (ADDR[15:12] == 4'h1);
    assign w_sel_sw  = (ADDR[15:12] == 4'h3);
    assign w_sel_tmr = (ADDR[15:12] == 4'h4);

    assign w_wr_ram    = W && w_sel_ram;
    assign w_wr_led    = W && w_sel_led;
    assign w_wr_ctrl   = W && w_sel_tmr && (ADDR[1:0] == 2'd0);
    assign w_wr_count  = W && w_sel_tmr && (ADDR[1:0] == 2'd1);
    assign w_wr_reload = W && w_sel_tmr && (ADDR[1:0] == 2'd2);
    assign w_tf_clear  = W && w_sel_tmr && (ADDR[1:0] == 2'd3) && DOUT[0];

    // Offset bits that only some targets decode; folded here so they count as read.
    assign w_unused = ^ADDR[11:0];

    // Timer next-state: hardware counting first, then bus writes override it.
    always_comb begin
        w_en_next    = r_en;
        w_ar_next    = r_ar;
        w_count_next = r_count;
        w_tf_set     = 1'b0;

        if (r_en) begin
            if (r_count != 16'd0) begin
                w_count_next = r_count - 16'd1;
                w_tf_set     = (r_count == 16'd1);
            end else if (r_ar) begin
                w_count_next = r_reload;
            end else begin
                w_en_next = 1'b0;
            end
        end

        // A bus write to COUNT wins over a decrement or reload in the same cycle.
        if (w_wr_count) begin
            w_count_next = DOUT;
        end
        // A bus write to CTRL wins over the hardware EN clear.
        if (w_wr_ctrl) begin
            w_en_next = DOUT[0];
            w_ar_next = DOUT[1];
        end

        // Terminal count sets TF even if software clears it on the same edge.
        if (w_tf_set) begin
            w_tf_next = 1'b1;
        end else if (w_tf_clear) begin
            w_tf_next = 1'b0;
        end else begin
            w_tf_next = r_tf;
        end
    end

    // Read mux: narrow fields zero-extended, unmapped space reads as zero.
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_sel_ram) begin
            w_rd_data = r_ram[ADDR[RAM_AW-1:0]];
        end else if (w_sel_led) begin
            w_rd_data = {{(16 - LED_W){1'b0}}, r_led};
        end else if (w_sel_sw) begin
            w_rd_data = {{(16 - SW_W){1'b0}}, r_sw_sync};
        end else if (w_sel_tmr) begin
            case (ADDR[1:0])
                2'd0:    w_rd_data = {14'h0000, r_ar, r_en};
                2'd1:    w_rd_data = r_count;
                2'd2:    w_rd_data = r_reload;
                default: w_rd_data = {15'h0000, r_tf};
            endcase
        end
    end

    // RAM write port; contents survive reset but writes during reset are dropped.
    always_ff @(posedge Clock) begin
        if (Resetn && w_wr_ram) begin
            r_ram[ADDR[RAM_AW-1:0]] <= DOUT;
        end
    end

    // Registered read data, LED register and switch synchronizer.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_din     <= 16'h0000;
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_din     <= w_rd_data;
            r_sw_meta <= SW;
            r_sw_sync <= r_sw_meta;
            if (w_wr_led) begin
                r_led <= DOUT[LED_W-1:0];
            end
        end
    end

    // Timer state register.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_en     <= 1'b0;
            r_ar     <= 1'b0;
            r_tf     <= 1'b0;
            r_count  <= 16'h0000;
            r_reload <= 16'h0000;
        end else begin
            r_en    <= w_en_next;
            r_ar    <= w_ar_next;
            r_tf    <= w_tf_next;
            r_count <= w_count_next;
            if (w_wr_reload) begin
                r_reload <= DOUT;
            end
        end
    end

    assign DIN  = r_din;
    assign LEDR = r_led;

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-mapped responder on the processor's external bus (ADDR, DOUT, W in; DIN out). It decodes each bus address into one of four targets: on-chip synchronous RAM, an LED output register, a synchronized switch input port, or a down-counting timer. It commits writes on the cycle W is high and returns read data with exactly one clock of latency, which matches the processor's fetch/load wait cycle. It is instantiated at the top level beside the processor.

## Interface
- RAM_AW, 8: RAM address width; RAM holds 2^RAM_AW 16-bit words.
- LED_W, 10: LED register width.
- SW_W, 10: switch input width.

- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  reset, synchronous and active-low.
- ADDR  in  16  bus address from the processor.
- DOUT  in  16  write data from the processor.
- W  in  1  write strobe; one cycle wide.
- DIN  out  16  registered read data to the processor.
- SW  in  SW_W  asynchronous switch inputs.
- LEDR  out  LED_W  LED register contents.

## Operation
- Decode on ADDR[15:12]:
  - 0x0: RAM, word index ADDR[RAM_AW-1:0]. Upper offset bits are ignored, so the RAM aliases.
  - 0x1: LEDR; any offset.
  - 0x3: SW; read-only, any offset.
  - 0x4: timer, register select ADDR[1:0]:
    - 0 CTRL: bit0 EN, bit1 AR (auto-reload).
    - 1 COUNT.
    - 2 RELOAD.
    - 3 STATUS: bit0 TF.
  - All other values: unmapped. Reads return 0; writes are ignored.
- Write (W=1 at an edge):
  - Target is selected by ADDR and loaded from DOUT.
  - LEDR takes DOUT[LED_W-1:0].
  - CTRL takes DOUT[1:0].
  - Writing STATUS with DOUT[0]=1 clears TF. DOUT[0]=0 has no effect.
  - Writes to SW are ignored.
- Read:
  - Every edge, DIN is loaded with the value addressed by ADDR, whether or not W is high.
  - Narrow fields are zero-extended to 16 bits.
  - SW reads return the synchronizer output.
- SW path: two-flop synchronizer. Reads reflect SW as it was two edges earlier.
- Timer, per edge with EN=1:
  - COUNT≠0: COUNT decrements by 1. If COUNT was 1, TF is set to 1.
  - COUNT=0 and AR=1: COUNT is loaded with RELOAD.
  - COUNT=0 and AR=0: COUNT holds and EN is cleared to 0.
  - With EN=0, COUNT holds.
- Simultaneous events:
  - A bus write to COUNT beats a decrement or reload in the same cycle.
  - A bus write to CTRL beats the hardware EN clear.
  - A hardware TF set beats a software TF clear in the same cycle; TF ends at 1.
- Arithmetic: 16-bit unsigned. COUNT never wraps below 0.

## Timing
- Read latency is 1 cycle. ADDR stable before edge k gives DIN valid after edge k, held until the next edge.
- Read-before-write: if W=1 and ADDR targets the same location at edge k, DIN after edge k shows the pre-write value. The new value is visible from edge k+1.
- Write latency: the target holds the new value after the edge where W=1. LEDR changes at that edge.
- Timer period with AR=1 and RELOAD=R: TF rises every R+1 cycles after the first terminal count.
- Reset (Resetn=0 at an edge), including mid-operation:
  - DIN=0, LEDR=0, CTRL=0, COUNT=0, RELOAD=0, TF=0, synchronizer flops=0.
  - Any W asserted in the same cycle is discarded.
  - RAM contents are not reset; they are retained through reset.
- No combinational path exists from any input to any output.

## Test plan
- RAM round trip: write 0x1234 to 0x0005, then drive ADDR=0x0005 with W=0 → DIN=0x1234 one edge later; ADDR=0x0105 also returns 0x1234 (alias).
- Read-before-write: RAM[3]=0xAAAA; W=1, ADDR=0x0003, DOUT=0x5555 at one edge → DIN=0xAAAA after that edge, 0x5555 after the next.
- LED/SW: write 0x03FF to 0x1000 → LEDR=0x3FF. SW=0x155 held, read 0x3000 → DIN=0x0155 no earlier than 3 edges after SW changes. Read 0x2000 → DIN=0.
- Timer one-shot: RELOAD=0, COUNT=3, CTRL=0x1 → TF=1 exactly 3 edges after the CTRL write; EN=0 one edge later; COUNT stays 0.
- Timer auto-reload and clear race: RELOAD=4, COUNT=1, CTRL=0x3; a STATUS clear write lands on the same edge TF sets → TF=1. TF sets again every 5 cycles.
- Reset mid-run: assert Resetn=0 for one edge while the timer is counting and LEDR=0x2A → all registers read 0 afterwards and RAM data written before reset reads back unchanged.
